// File: rtl/ecr_pkg.sv
// Shared types and helpers for the execution condition register bank.
package ecr_pkg;

    // Lock state of one condition register.
    typedef enum logic {
        FREE = 1'b0,
        HELD = 1'b1
    } ecr_state_e;

    // Widest issue ID the age helper accepts.
    localparam int unsigned MAX_ID_WIDTH = 32;

    // a is older than b when the MSB of (a - b) mod 2^id_width is set.
    // Bits above id_width cannot influence bit id_width-1 of the difference,
    // so callers may pass zero-extended IDs of any width up to MAX_ID_WIDTH.
    // Equal IDs give a zero difference, hence neither is older.
    function automatic logic is_older(
        input logic [MAX_ID_WIDTH-1:0] a,
        input logic [MAX_ID_WIDTH-1:0] b,
        input int unsigned             id_width
    );
        logic [MAX_ID_WIDTH-1:0] w_diff;
        logic [MAX_ID_WIDTH-1:0] w_shifted;
        w_diff    = a - b;
        w_shifted = w_diff >> (id_width - 1);
        return w_shifted[0];
    endfunction

endpackage

// File: rtl/ecr_lock_slot.sv
// One condition register: exclusive write-lock FSM, age arbiter for
// acquisition, read/write grant generation and the committed value.
module ecr_lock_slot
    import ecr_pkg::*;
#(
    parameter int                    NUM_SICS    = 4,
    parameter int                    ID_WIDTH    = 4,
    parameter int                    DATA_WIDTH  = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_SICS-1:0]                  i_req_read,
    input  logic [NUM_SICS-1:0]                  i_req_write,
    input  logic [NUM_SICS-1:0][ID_WIDTH-1:0]    i_issue_id,
    input  logic [NUM_SICS-1:0]                  i_release,
    input  logic [NUM_SICS-1:0][DATA_WIDTH-1:0]  i_wdata,
    input  logic                                 i_flush_valid,
    input  logic [ID_WIDTH-1:0]                  i_flush_id,
    output logic [NUM_SICS-1:0]                  o_grant,
    output logic [DATA_WIDTH-1:0]                o_value,
    output logic                                 o_busy,
    output logic                                 o_bad_release
);

    localparam int PORT_W = (NUM_SICS > 1) ? $clog2(NUM_SICS) : 1;

    ecr_state_e          r_state;
    logic [PORT_W-1:0]   r_owner_port;
    logic [ID_WIDTH-1:0] r_owner_id;
    logic [DATA_WIDTH-1:0] r_value;

    logic                w_any_write;
    logic [PORT_W-1:0]   w_win_port;
    logic [ID_WIDTH-1:0] w_win_id;
    logic [NUM_SICS-1:0] w_is_owner;
    logic                w_squash;
    logic                w_owner_release;

    function automatic logic older(input logic [ID_WIDTH-1:0] a, input logic [ID_WIDTH-1:0] b);
        return is_older(MAX_ID_WIDTH'(a), MAX_ID_WIDTH'(b), ID_WIDTH);
    endfunction

    // Age arbiter: oldest requesting ID wins; strict comparison keeps the lowest port on ties.
    always_comb begin
        w_any_write = 1'b0;
        w_win_port  = '0;
        w_win_id    = '0;
        for (int s = 0; s < NUM_SICS; s++) begin
            if (i_req_write[s] && (!w_any_write || older(i_issue_id[s], w_win_id))) begin
                w_any_write = 1'b1;
                w_win_port  = PORT_W'(s);
                w_win_id    = i_issue_id[s];
            end
        end
    end

    // Per-port ownership, combined grants and bad-release detection.
    always_comb begin
        o_bad_release = 1'b0;
        for (int s = 0; s < NUM_SICS; s++) begin
            w_is_owner[s] = (r_state == HELD) && (r_owner_port == PORT_W'(s));
            // A reader passes if the slot is free, it is older than the owner, or it is the owner.
            o_grant[s]    = w_is_owner[s] |
                            (i_req_read[s] && ((r_state == FREE) ||
                                               older(i_issue_id[s], r_owner_id) ||
                                               w_is_owner[s]));
            o_bad_release = o_bad_release | (i_release[s] & ~w_is_owner[s]);
        end
    end

    // Flush only squashes owners strictly younger than the surviving flush ID.
    assign w_squash        = (r_state == HELD) && i_flush_valid && older(i_flush_id, r_owner_id);
    assign w_owner_release = i_release[r_owner_port];

    // Lock FSM: acquisition when free and no flush, release or squash when held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= FREE;
            r_owner_port <= '0;
            r_owner_id   <= '0;
            r_value      <= RESET_VALUE;
        end else begin
            case (r_state)
                FREE: begin
                    if (w_any_write && !i_flush_valid) begin
                        r_state      <= HELD;
                        r_owner_port <= w_win_port;
                        r_owner_id   <= w_win_id;
                    end
                end
                HELD: begin
                    // Squash takes priority: the owner's pending value is discarded.
                    if (w_squash) begin
                        r_state <= FREE;
                    end else if (w_owner_release) begin
                        r_state <= FREE;
                        r_value <= i_wdata[r_owner_port];
                    end
                end
                default: r_state <= FREE;
            endcase
        end
    end

    assign o_value = r_value;
    assign o_busy  = (r_state == HELD);

endmodule

// File: rtl/execution_condition_register_bank.sv
// Bank of lockable execution condition registers shared by the SIC array.
// SIC-facing buses are [SIC][ECR]; each slot works on an ECR-major view.
module execution_condition_register_bank
    import ecr_pkg::*;
#(
    parameter int                    NUM_ECRS    = 4,
    parameter int                    NUM_SICS    = 4,
    parameter int                    ID_WIDTH    = 4,
    parameter int                    DATA_WIDTH  = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic [NUM_SICS-1:0][NUM_ECRS-1:0]                  sic_req_read,
    input  logic [NUM_SICS-1:0][NUM_ECRS-1:0]                  sic_req_write,
    input  logic [NUM_SICS-1:0][NUM_ECRS-1:0][ID_WIDTH-1:0]    sic_issue_id,
    input  logic [NUM_SICS-1:0][NUM_ECRS-1:0]                  sic_release,
    input  logic [NUM_SICS-1:0][NUM_ECRS-1:0][DATA_WIDTH-1:0]  sic_wdata,
    output logic [NUM_SICS-1:0][NUM_ECRS-1:0][DATA_WIDTH-1:0]  sic_rdata_out,
    output logic [NUM_SICS-1:0][NUM_ECRS-1:0]                  sic_grant_out,
    input  logic                                               flush_valid,
    input  logic [ID_WIDTH-1:0]                                flush_id,
    output logic [NUM_ECRS-1:0][DATA_WIDTH-1:0]                monitor_states,
    output logic [NUM_ECRS-1:0]                                monitor_busy,
    output logic                                               err_bad_release
);

    logic [NUM_ECRS-1:0] w_bad_release;
    logic                r_err_bad_release;

    for (genvar e = 0; e < NUM_ECRS; e++) begin : g_slot
        logic [NUM_SICS-1:0]                 w_req_read;
        logic [NUM_SICS-1:0]                 w_req_write;
        logic [NUM_SICS-1:0][ID_WIDTH-1:0]   w_issue_id;
        logic [NUM_SICS-1:0]                 w_release;
        logic [NUM_SICS-1:0][DATA_WIDTH-1:0] w_wdata;
        logic [NUM_SICS-1:0]                 w_grant;
        logic [DATA_WIDTH-1:0]               w_value;
        logic                                w_busy;

        for (genvar s = 0; s < NUM_SICS; s++) begin : g_sic
            assign w_req_read[s]        = sic_req_read[s][e];
            assign w_req_write[s]       = sic_req_write[s][e];
            assign w_issue_id[s]        = sic_issue_id[s][e];
            assign w_release[s]         = sic_release[s][e];
            assign w_wdata[s]           = sic_wdata[s][e];
            assign sic_grant_out[s][e]  = w_grant[s];
            assign sic_rdata_out[s][e]  = w_value;
        end

        ecr_lock_slot #(
            .NUM_SICS    (NUM_SICS),
            .ID_WIDTH    (ID_WIDTH),
            .DATA_WIDTH  (DATA_WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_slot (
            .clk           (clk),
            .rst           (rst),
            .i_req_read    (w_req_read),
            .i_req_write   (w_req_write),
            .i_issue_id    (w_issue_id),
            .i_release     (w_release),
            .i_wdata       (w_wdata),
            .i_flush_valid (flush_valid),
            .i_flush_id    (flush_id),
            .o_grant       (w_grant),
            .o_value       (w_value),
            .o_busy        (w_busy),
            .o_bad_release (w_bad_release[e])
        );

        assign monitor_states[e] = w_value;
        assign monitor_busy[e]   = w_busy;
    end

    // Sticky error: any slot seeing a non-owner release sets it until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_bad_release <= 1'b0;
        end else if (|w_bad_release) begin
            r_err_bad_release <= 1'b1;
        end
    end

    assign err_bad_release = r_err_bad_release;

endmodule
